// File: rtl/char_glyph_rom.sv
// Character glyph responder: 11-glyph 8x16 font RAM, default-font loader after reset,
// runtime font rewrites, upscaled pixel lookup with one-cycle latency and colon blinking.
module char_glyph_rom #(
  parameter int CHAR_W       = 128,
  parameter int DOT_W        = 32,
  parameter int HIGHT        = 128,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] char_num,
  input  logic [9:0] char_x_loc,
  input  logic [9:0] char_y_loc,
  input  logic       char_data_req,
  output logic       char_data,
  input  logic       colon_blink,
  input  logic       font_wr_en,
  input  logic [7:0] font_wr_addr,
  input  logic [7:0] font_wr_data,
  output logic       font_busy
);

  localparam int NUM_GLYPHS = 11;
  localparam int FONT_DEPTH = NUM_GLYPHS * GLYPH_H;
  localparam int DIG_SH     = $clog2(CHAR_W / GLYPH_W);
  localparam int DOT_SH     = $clog2(DOT_W / GLYPH_W);
  localparam int ROW_SH     = $clog2(HIGHT / GLYPH_H);
  localparam int CW         = $clog2(GLYPH_W);
  localparam int RW         = $clog2(GLYPH_H);
  localparam int BW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q;
  logic [7:0]      init_ptr_q;
  logic            font_busy_q;
  logic [BW-1:0]   blink_cnt_q;
  logic            blink_phase_q;
  logic            char_data_q;
  logic [7:0]      font_mem [0:FONT_DEPTH-1];

  logic            wr_en_s;
  logic [7:0]      wr_addr_s;
  logic [7:0]      wr_data_s;
  logic            is_colon_s;
  logic            x_ok_s;
  logic            y_ok_s;
  logic            hit_s;
  logic [CW-1:0]   col_s;
  logic [CW-1:0]   bit_idx_s;
  logic [RW-1:0]   row_s;
  logic [7:0]      rd_addr_s;

  // Segment set per digit is {a,b,c,d,e,f,g}; column c maps to bit 7-c.
  function automatic logic [7:0] default_row(input logic [3:0] glyph, input logic [3:0] row);
    logic [6:0] seg;
    logic [7:0] r;
    case (glyph)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    r = 8'h00;
    if (glyph == 4'd10) begin
      r = (row == 4'd4 || row == 4'd5 || row == 4'd10 || row == 4'd11) ? 8'h18 : 8'h00;
    end else begin
      r = r | ((seg[6] && row == 4'd1) ? 8'h7E : 8'h00);
      r = r | ((seg[0] && (row == 4'd7 || row == 4'd8)) ? 8'h7E : 8'h00);
      r = r | ((seg[3] && row == 4'd14) ? 8'h7E : 8'h00);
      r = r | ((seg[1] && row >= 4'd1 && row <= 4'd7) ? 8'h40 : 8'h00);
      r = r | ((seg[5] && row >= 4'd1 && row <= 4'd7) ? 8'h02 : 8'h00);
      r = r | ((seg[2] && row >= 4'd8 && row <= 4'd14) ? 8'h40 : 8'h00);
      r = r | ((seg[4] && row >= 4'd8 && row <= 4'd14) ? 8'h02 : 8'h00);
    end
    return r;
  endfunction

  // Single write port shared by the default-font loader and runtime rewrites.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = 8'h00;
    wr_data_s = 8'h00;
    if (rst) begin
      wr_en_s = 1'b0;
    end else if (state_q == ST_INIT) begin
      wr_en_s   = 1'b1;
      wr_addr_s = init_ptr_q;
      wr_data_s = default_row(init_ptr_q[7:4], init_ptr_q[3:0]);
    end else if (font_wr_en && (font_wr_addr[7:4] <= 4'd10)) begin
      wr_en_s   = 1'b1;
      wr_addr_s = font_wr_addr;
      wr_data_s = font_wr_data;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Pixel lookup decode: scale screen coordinates down to font row/column.
  always_comb begin
    is_colon_s = (char_num == 4'd10);
    x_ok_s     = is_colon_s ? ({1'b0, char_x_loc} < 11'(DOT_W))
                            : ({1'b0, char_x_loc} < 11'(CHAR_W));
    y_ok_s     = ({1'b0, char_y_loc} < 11'(HIGHT));
    col_s      = is_colon_s ? CW'(char_x_loc >> DOT_SH) : CW'(char_x_loc >> DIG_SH);
    bit_idx_s  = ~col_s;
    row_s      = RW'(char_y_loc >> ROW_SH);
    rd_addr_s  = {char_num, row_s};
    hit_s      = (state_q == ST_RUN) && char_data_req && (char_num <= 4'd10) &&
                 x_ok_s && y_ok_s && !(is_colon_s && colon_blink && !blink_phase_q);
  end

  // Font RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      font_mem[wr_addr_s] <= wr_data_s;
    end
  end

  // Synchronous read port; the same-edge write is not yet visible (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      char_data_q <= 1'b0;
    end else begin
      char_data_q <= hit_s ? font_mem[rd_addr_s][bit_idx_s] : 1'b0;
    end
  end

  // Controller: font initialisation sequence, then free-running blink timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      init_ptr_q    <= 8'd0;
      font_busy_q   <= 1'b1;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_ptr_q <= init_ptr_q + 8'd1;
          if (init_ptr_q == 8'(FONT_DEPTH - 1)) begin
            state_q     <= ST_RUN;
            font_busy_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
          end else begin
            blink_cnt_q <= blink_cnt_q + {{(BW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_q     <= ST_INIT;
          init_ptr_q  <= 8'd0;
          font_busy_q <= 1'b1;
        end
      endcase
    end
  end

  assign char_data = char_data_q;
  assign font_busy = font_busy_q;

endmodule

// File: tb/tb_char_glyph_rom.sv
// Randomised bench for char_glyph_rom against a pixel-level font model built
// from segment descriptions, with a cycle-count view of init and blink timing.
module tb_char_glyph_rom;

  localparam int BLINK_N   = 4;
  localparam int RUN_START = 176;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] char_num;
  logic [9:0] char_x_loc;
  logic [9:0] char_y_loc;
  logic       char_data_req;
  logic       char_data;
  logic       colon_blink;
  logic       font_wr_en;
  logic [7:0] font_wr_addr;
  logic [7:0] font_wr_data;
  logic       font_busy;

  always #5 clk = ~clk;

  char_glyph_rom #(.BLINK_CYCLES(BLINK_N)) dut (
    .clk          (clk),
    .rst          (rst),
    .char_num     (char_num),
    .char_x_loc   (char_x_loc),
    .char_y_loc   (char_y_loc),
    .char_data_req(char_data_req),
    .char_data    (char_data),
    .colon_blink  (colon_blink),
    .font_wr_en   (font_wr_en),
    .font_wr_addr (font_wr_addr),
    .font_wr_data (font_wr_data),
    .font_busy    (font_busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int v     = 0;   // non-reset clock edges since the last reset edge
  logic [7:0] ref_font [0:10][0:15];
  string seg_sets [10] = '{"abcdef", "bc", "abged", "abgcd", "fgbc",
                           "afgcd", "afgedc", "abc", "abcdefg", "abcdfg"};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit pix_default(int g, int r, int c);
    bit on;
    on = 1'b0;
    if (g == 10) return ((r == 4 || r == 5 || r == 10 || r == 11) && (c == 3 || c == 4));
    for (int i = 0; i < seg_sets[g].len(); i++) begin
      case (seg_sets[g][i])
        "a": on |= (r == 1 && c >= 1 && c <= 6);
        "g": on |= ((r == 7 || r == 8) && c >= 1 && c <= 6);
        "d": on |= (r == 14 && c >= 1 && c <= 6);
        "f": on |= (c == 1 && r >= 1 && r <= 7);
        "b": on |= (c == 6 && r >= 1 && r <= 7);
        "e": on |= (c == 1 && r >= 8 && r <= 14);
        "c": on |= (c == 6 && r >= 8 && r <= 14);
        default: on |= 1'b0;
      endcase
    end
    return on;
  endfunction

  task automatic load_default();
    for (int g = 0; g <= 10; g++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 8; c++)
          ref_font[g][r][7-c] = pix_default(g, r, c);
  endtask

  function automatic bit exp_pixel(int num, int x, int y, bit req, bit blink, int cyc);
    int wlim;
    if (!req || cyc < RUN_START || num > 10) return 1'b0;
    wlim = (num == 10) ? 32 : 128;
    if (x >= wlim || y >= 128) return 1'b0;
    if (num == 10 && blink && (((cyc - RUN_START) / BLINK_N) % 2) == 1) return 1'b0;
    return ref_font[num][y / 8][7 - x / (wlim / 8)];
  endfunction

  task automatic step(input string tag);
    bit e;
    e = exp_pixel(int'(char_num), int'(char_x_loc), int'(char_y_loc),
                  char_data_req, colon_blink, v);
    if (!rst && v >= RUN_START && font_wr_en && font_wr_addr[7:4] <= 4'd10)
      ref_font[font_wr_addr[7:4]][font_wr_addr[3:0]] = font_wr_data;
    @(posedge clk);
    if (rst) begin
      v = 0;
      e = 1'b0;
      load_default();
    end else begin
      v++;
    end
    @(negedge clk);
    check_val({tag, "_data"}, 32'(char_data), 32'(e));
    check_val({tag, "_busy"}, 32'(font_busy), 32'(v < RUN_START));
  endtask

  task automatic rand_inputs(input bit allow_wr);
    char_num      = 4'($urandom_range(0, 15));
    char_x_loc    = 10'($urandom_range(0, 159));
    char_y_loc    = 10'($urandom_range(0, 143));
    char_data_req = ($urandom_range(0, 7) != 0);
    colon_blink   = 1'($urandom_range(0, 1));
    font_wr_en    = allow_wr && ($urandom_range(0, 15) == 0);
    font_wr_addr  = 8'($urandom_range(0, 255));
    font_wr_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic lookup(input int num, input int x, input int y, input string tag);
    char_num = 4'(num); char_x_loc = 10'(x); char_y_loc = 10'(y); char_data_req = 1'b1;
    step(tag);
  endtask

  initial begin
    load_default();
    rst = 1'b1;
    rand_inputs(1'b1);
    char_data_req = 1'b1;
    for (int i = 0; i < 3; i++) step("reset");
    rst = 1'b0;
    for (int i = 0; i < RUN_START; i++) begin
      rand_inputs(1'b1);
      char_data_req = 1'b1;
      step("init");
    end

    font_wr_en = 1'b0; colon_blink = 1'b0;
    lookup(1, 96, 8, "dig1_on");
    lookup(1, 0, 8, "dig1_off");
    lookup(10, 12, 32, "colon_on");
    lookup(10, 12, 0, "colon_row0");
    lookup(10, 32, 32, "colon_xoor");
    lookup(1, 96, 128, "dig1_yoor");

    font_wr_en = 1'b1; font_wr_addr = 8'h23; font_wr_data = 8'hFF;
    lookup(2, 0, 24, "wr_same");
    font_wr_en = 1'b0;
    lookup(2, 0, 24, "wr_after");
    font_wr_en = 1'b1; font_wr_addr = 8'hB0; font_wr_data = 8'hFF;
    lookup(0, 0, 0, "wr_drop_same");
    font_wr_en = 1'b0;
    for (int c = 0; c < 8; c++) lookup(0, c * 16, 0, "wr_drop");
    for (int c = 0; c < 8; c++) lookup(10, c * 4, 0, "wr_drop_colon");

    colon_blink = 1'b1;
    for (int i = 0; i < 24; i++) lookup(10, 12, 32, "blink_on");
    colon_blink = 1'b0;
    for (int i = 0; i < 8; i++) lookup(10, 12, 32, "blink_off");
    colon_blink = 1'b1;
    for (int i = 0; i < 8; i++) lookup(8, 48, 8, "blink_digit");

    for (int i = 0; i < 1500; i++) begin
      rand_inputs(1'b1);
      step("rand");
    end

    rst = 1'b1; font_wr_en = 1'b0; step("rst2");
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin rand_inputs(1'b1); step("init2"); end
    rst = 1'b1; step("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < RUN_START; i++) begin rand_inputs(1'b1); step("init3"); end
    font_wr_en = 1'b0;
    for (int i = 0; i < 4; i++) lookup(11, 8 * i, 8 * i, "blank11");
    lookup(1, 96, 8, "dig1_after");
    for (int i = 0; i < 300; i++) begin rand_inputs(1'b1); step("rand2"); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/char_glyph_rom.md
Name: char_glyph_rom

Overview:
- Responder side of the pixel-data character interface on the VGA digital-alarm display.
- The pixel generator issues char_num, char_x_loc, char_y_loc and char_data_req, then samples char_data exactly one cycle later.
- This block returns the glyph bit. It stores an 8x16 font of 11 glyphs (digits 0-9, colon = 10) in RAM and upscales it to the on-screen character size.
- It also initialises the font after reset, accepts runtime font rewrites, and can blink the colon.

Parameters:
CHAR_W, 128, on-screen digit width in pixels (must be GLYPH_W x 2^n)
DOT_W, 32, on-screen colon width in pixels (must be GLYPH_W x 2^m)
HIGHT, 128, on-screen glyph height in pixels (must be GLYPH_H x 2^k)
GLYPH_W, 8, stored font columns per row
GLYPH_H, 16, stored font rows per glyph
BLINK_CYCLES, 25000000, clock cycles per colon blink half-period

Ports:
clk  in  1  pixel clock
rst  in  1  reset; synchronous, active-high
char_num  in  4  glyph select: 0-9 digit, 10 colon, 11-15 blank
char_x_loc  in  10  pixel column inside the current character cell
char_y_loc  in  10  pixel row inside the current character cell
char_data_req  in  1  lookup request
char_data  out  1  glyph bit, valid the cycle after the request
colon_blink  in  1  1 = colon blinks, 0 = colon always shown
font_wr_en  in  1  font write strobe
font_wr_addr  in  8  [7:4] glyph, [3:0] row
font_wr_data  in  8  row bits; bit7 = column 0 (leftmost)
font_busy  out  1  high during post-reset initialisation

Behaviour:
- Storage: 11x16x8-bit font RAM with a synchronous read port and one write port.
- Reset values: char_data=0, font_busy=1, blink counter=0, blink phase=1 (colon shown), FSM=INIT, init pointer=0.
- FSM INIT:
  - Each cycle writes the default row for (glyph, row) at the init pointer, then increments the pointer.
  - Runs 176 cycles (11 glyphs x 16 rows), then moves to RUN; font_busy drops in the first RUN cycle.
  - While in INIT, char_data=0 and font_wr_en is ignored.
- FSM RUN has no exit. Asserting rst in any state, including mid-INIT, restarts INIT at pointer 0.
- Default font (row r, col c):
  - Digits use seven-segment strokes: a = r1, c1-6; g = r7-8, c1-6; d = r14, c1-6; f = c1, r1-7; b = c6, r1-7; e = c1, r8-14; c = c6, r8-14. Standard segment sets per digit.
  - Colon: rows 4,5,10,11 = 8'h18; all other rows = 0.
- Lookup (RUN, char_data_req=1), registered into char_data on the next edge, latency exactly 1 cycle:
  - Digit: col = char_x_loc >> log2(CHAR_W/GLYPH_W), valid when char_x_loc < CHAR_W.
  - Colon: col = char_x_loc >> log2(DOT_W/GLYPH_W), valid when char_x_loc < DOT_W.
  - row = char_y_loc >> log2(HIGHT/GLYPH_H), valid when char_y_loc < HIGHT.
  - char_data = font[char_num][row][7-col].
- char_data=0 on the next cycle when any of these holds: char_data_req=0; char_num>10; x or y out of range; char_num=10 with colon_blink=1 and blink phase=0.
- Blink: the counter runs in RUN only, counts 0..BLINK_CYCLES-1, wraps, and toggles the phase on wrap. colon_blink=0 does not stop the counter.
- Write (RUN, font_wr_en=1):
  - Writes font_wr_data to row [3:0] of glyph [7:4].
  - Writes with glyph >10 are dropped.
  - The write takes effect for lookups from the next cycle on.
  - A same-cycle read of the address being written returns the old data (read-before-write).
- No backpressure: a request is accepted every cycle, and back-to-back requests give back-to-back results.

Test Plan:
- Reset: hold rst 3 cycles, release -> font_busy=1 for 176 cycles then 0; char_data=0 throughout, even with char_data_req=1.
- Digit 1, default font, RUN: req=1, num=1, y=8 (row 1), x=96 (col 6) -> char_data=1 next cycle; x=0 -> 0.
- Colon: num=10, y=32 (row 4), x=12 (col 3) -> 1; y=0 -> 0; x=32 (out of range) -> 0.
- Write: font_wr_addr=8'h23, data=8'hFF, then num=2, y=24, x=0 -> 1. Same-cycle read of that address during the write returns the old row bit. font_wr_addr=8'hB0 -> no change to any glyph.
- Blink with BLINK_CYCLES=4, colon_blink=1: colon lit pixel reads 1 for 4 cycles, 0 for 4, repeating. colon_blink=0 -> always 1. Digits are unaffected.
- rst pulsed at INIT cycle 100 -> busy stays high a further full 176 cycles; num=11 in RUN -> 0.
